darkriscv_core: RTL and testbench
=================================

# darkriscv_core

Compact 32-bit RISC-V core (RV32I integer subset) with a two-stage fetch/execute pipeline. It sits between a synchronous instruction memory and a data bus in the SoC, and is exercised stand-alone by the core testbench through the CPU interface bundle. The core has no caches and no CSRs; interrupts and simulation hooks are outside this block's scope.

## Interface
- CPTR, 0: core identifier; reserved for multi-core SoCs, no effect on behaviour.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- RESET_SP, 32'h0000_2000: value loaded into x2 on reset.

Ports:
- CLK  in  1  single clock, rising edge.
- RES  in  1  reset; one clock; reset is asynchronous and active-low.
- HLT  in  1  stall; when 1, all state freezes.
- IDATA  in  32  instruction word for the IADDR of the previous cycle.
- IADDR  out  32  instruction fetch address (current PC).
- DADDR  out  32  data address (rs1 + imm).
- DATAI  in  32  load data.
- DATAO  out  32  store data, lane-replicated.
- DLEN  out  3  access size, one-hot: 001 byte, 010 half, 100 word.
- DRW  out  1  1 = read (load), 0 = write (store).
- DWR  out  1  store strobe.
- DRD  out  1  load strobe.
- DAS  out  1  data access strobe, DRD | DWR.
- DEBUG  out  4  {~RES, flush, DRD, DWR}.

## Operation
- Supports LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, and all OP-IMM and OP ALU instructions. FENCE, SYSTEM and unknown opcodes execute as NOP.
- Register file has 32×32 entries; x0 always reads 0, and writes to it are discarded.
- Stage 1 (fetch): IADDR = PC. IDATA is latched into the instruction register.
- Stage 2 (execute): decode, ALU, branch resolve, memory strobe and write-back all happen in the same cycle.
- Shift amount is rs2[4:0] or imm[4:0]. SRA/SRAI are arithmetic. SLT is signed; SLTU is unsigned. Arithmetic is modulo 2^32.
- Loads: lane selected by DADDR[1:0] (byte) or DADDR[1] (half). The value is sign- or zero-extended per funct3. Word loads ignore DADDR[1:0].
- Stores: byte is replicated ×4 and half ×2 on DATAO. DLEN tells the bus which lanes to write.
- JAL/JALR write PC+4 to rd. JALR target has bit 0 cleared.

## Timing
- Reset (RES=0), asynchronous:
  - PC = RESET_PC, x2 = RESET_SP, instruction register = NOP, flush = 1.
  - DRD = DWR = DAS = 0, DRW = 1, DATAO = 0, DLEN = 100.
  - Other registers are undefined.
- First instruction executes in the second cycle after RES rises; the first execute slot is a flush bubble.
- Sequential: PC advances by 4 per non-stalled cycle, giving one instruction per cycle.
- Taken branch or jump in cycle n:
  - IADDR = target in cycle n+1.
  - The instruction fetched during cycle n is squashed (flush = 1 in n+1, no register or memory side effects).
  - Penalty is one cycle.
- Loads and stores: strobes, DADDR, DLEN and DATAO are combinational in the execute cycle. DATAI is sampled at the rising edge ending that cycle, provided HLT = 0.
- HLT = 1 holds PC, the instruction register, the register file and the flush flag. Strobes remain asserted, so the bus can extend an access arbitrarily.
- Reset asserted mid-access drops the strobes immediately. No partial write-back occurs.

## Structure
- Package darkriscv_pkg holds:
  - opcode and funct3 constants;
  - DLEN encodings;
  - the NOP encoding (32'h0000_0013);
  - default RESET_PC and RESET_SP.
- Sub-module darkriscv_alu is combinational: operands, funct3 and funct7[5] in; result and branch-compare outputs out.
- The top level holds the PC, the instruction register, the register file, load/store lane logic and the flush control.

## Test plan
- Reset with RESET_PC = 0 and RESET_SP = 0x2000; release → IADDR = 0, then 4, 8. A program storing x2 to 0x100 writes 0x2000.
- ADDI x1,x0,5; ADDI x2,x1,-7; SLTU x3,x1,x2 → x1 = 5, x2 = 0xFFFF_FFFE, x3 = 1. ADDI x0,x0,9 → x0 reads 0.
- BEQ x0,x0,+8 at 0x10 → IADDR becomes 0x18. The squashed instruction at 0x14 (ADDI x5,x0,1) leaves x5 unchanged.
- SB of 0xA5 to 0x103 → DATAO = 0xA5A5_A5A5, DLEN = 001, DWR = DAS = 1, DRW = 0. LB from 0x103 with DATAI = 0xA5xx_xxxx → rd = 0xFFFF_FFA5; LBU → 0x0000_00A5.
- HLT held for 3 cycles during LW → IADDR and strobes stable. rd is written with the DATAI present on the first edge with HLT = 0.
- RES low during a store cycle → DWR and DAS drop to 0 immediately. After release, execution restarts at RESET_PC.

Source files
------------

// File: rtl/darkriscv_pkg.sv
// Shared encodings for the darkriscv RV32I core: opcodes, funct3 codes,
// bus access sizes and reset defaults.
package darkriscv_pkg;

   typedef enum logic [6:0] {
      OPC_LUI    = 7'b0110111,
      OPC_AUIPC  = 7'b0010111,
      OPC_JAL    = 7'b1101111,
      OPC_JALR   = 7'b1100111,
      OPC_BRANCH = 7'b1100011,
      OPC_LOAD   = 7'b0000011,
      OPC_STORE  = 7'b0100011,
      OPC_OPIMM  = 7'b0010011,
      OPC_OP     = 7'b0110011
   } opcode_e;

   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;

   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   localparam logic [2:0] F3_LB   = 3'd0;
   localparam logic [2:0] F3_LH   = 3'd1;
   localparam logic [2:0] F3_LW   = 3'd2;
   localparam logic [2:0] F3_LBU  = 3'd4;
   localparam logic [2:0] F3_LHU  = 3'd5;

   localparam logic [2:0] DLEN_BYTE = 3'b001;
   localparam logic [2:0] DLEN_HALF = 3'b010;
   localparam logic [2:0] DLEN_WORD = 3'b100;

   localparam logic [31:0] NOP_INSN     = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] DEF_RESET_SP = 32'h0000_2000;

endpackage

// File: rtl/darkriscv_alu.sv
// Combinational RV32I integer ALU; also supplies the three compare flags
// that branch resolution needs.
module darkriscv_alu
   import darkriscv_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  funct3_i,
   input  logic        alt_i,
   output logic [31:0] result_o,
   output logic        eq_o,
   output logic        lt_o,
   output logic        ltu_o
);

   logic [4:0] shamt;

   assign shamt = b_i[4:0];
   assign eq_o  = (a_i == b_i);
   assign lt_o  = ($signed(a_i) < $signed(b_i));
   assign ltu_o = (a_i < b_i);

   // alt_i selects SUB over ADD and arithmetic over logical right shift.
   always_comb begin
      result_o = '0;
      case (funct3_i)
         F3_ADD:  result_o = alt_i ? (a_i - b_i) : (a_i + b_i);
         F3_SLL:  result_o = a_i << shamt;
         F3_SLT:  result_o = {31'd0, lt_o};
         F3_SLTU: result_o = {31'd0, ltu_o};
         F3_XOR:  result_o = a_i ^ b_i;
         F3_SR:   result_o = alt_i ? 32'($signed(a_i) >>> shamt) : (a_i >> shamt);
         F3_OR:   result_o = a_i | b_i;
         F3_AND:  result_o = a_i & b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/darkriscv_core.sv
// Two-stage (fetch/execute) RV32I core: PC, instruction register, register
// file, load/store lane handling and branch flush control.
module darkriscv_core
   import darkriscv_pkg::*;
#(
   parameter int          CPTR     = 0,
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] RESET_SP = DEF_RESET_SP
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        HLT,
   input  logic [31:0] IDATA,
   output logic [31:0] IADDR,
   output logic [31:0] DADDR,
   input  logic [31:0] DATAI,
   output logic [31:0] DATAO,
   output logic [2:0]  DLEN,
   output logic        DRW,
   output logic        DWR,
   output logic        DRD,
   output logic        DAS,
   output logic [3:0]  DEBUG
);

   if (CPTR < 0) begin : gInvalidCptr
   end

   logic [31:0] pc_q, pc_d, ir_q, inst;
   logic        flush_q, flush_d, halted_q;
   logic [31:0] regs_q [32];

   // While stalled the memory may move on, so the stalled instruction is replayed from ir_q.
   assign inst = flush_q ? NOP_INSN : (halted_q ? ir_q : IDATA);

   logic [6:0]  opcode;
   logic [4:0]  rd, rs1Idx, rs2Idx;
   logic [2:0]  funct3;
   logic [31:0] immI, immS, immB, immU, immJ, rs1Val, rs2Val, pcExec;

   assign opcode = inst[6:0];
   assign rd     = inst[11:7];
   assign funct3 = inst[14:12];
   assign rs1Idx = inst[19:15];
   assign rs2Idx = inst[24:20];
   assign immI   = {{20{inst[31]}}, inst[31:20]};
   assign immS   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign immB   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign immU   = {inst[31:12], 12'd0};
   assign immJ   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign rs1Val = (rs1Idx == 5'd0) ? '0 : regs_q[rs1Idx];
   assign rs2Val = (rs2Idx == 5'd0) ? '0 : regs_q[rs2Idx];
   assign pcExec = pc_q - 32'd4;

   logic isLui, isAuipc, isJal, isJalr, isBranch, isLoad, isStore, isOpImm, isOp;

   assign isLui    = (opcode == OPC_LUI);
   assign isAuipc  = (opcode == OPC_AUIPC);
   assign isJal    = (opcode == OPC_JAL);
   assign isJalr   = (opcode == OPC_JALR);
   assign isBranch = (opcode == OPC_BRANCH);
   assign isLoad   = (opcode == OPC_LOAD);
   assign isStore  = (opcode == OPC_STORE);
   assign isOpImm  = (opcode == OPC_OPIMM);
   assign isOp     = (opcode == OPC_OP);

   logic [31:0] aluB, aluResult;
   logic        aluAlt, cmpEq, cmpLt, cmpLtu;

   assign aluB   = (isOp || isBranch) ? rs2Val : immI;
   assign aluAlt = (isOp || (isOpImm && funct3 == F3_SR)) && inst[30];

   darkriscv_alu uAlu (
      .a_i      (rs1Val),
      .b_i      (aluB),
      .funct3_i (funct3),
      .alt_i    (aluAlt),
      .result_o (aluResult),
      .eq_o     (cmpEq),
      .lt_o     (cmpLt),
      .ltu_o    (cmpLtu)
   );

   logic        taken, branchCond;
   logic [31:0] target, jalrSum;

   assign jalrSum = rs1Val + immI;

   always_comb begin
      branchCond = 1'b0;
      case (funct3)
         F3_BEQ:  branchCond = cmpEq;
         F3_BNE:  branchCond = !cmpEq;
         F3_BLT:  branchCond = cmpLt;
         F3_BGE:  branchCond = !cmpLt;
         F3_BLTU: branchCond = cmpLtu;
         F3_BGEU: branchCond = !cmpLtu;
         default: branchCond = 1'b0;
      endcase
   end

   assign taken  = isJal || isJalr || (isBranch && branchCond);
   assign target = isJalr ? {jalrSum[31:1], 1'b0} : (pcExec + (isJal ? immJ : immB));

   always_comb begin
      pc_d    = pc_q + 32'd4;
      flush_d = 1'b0;
      if (taken) begin
         pc_d    = target;
         flush_d = 1'b1;
      end
   end

   assign DADDR = rs1Val + (isStore ? immS : immI);
   assign DRD   = isLoad;
   assign DWR   = isStore;
   assign DAS   = isLoad || isStore;
   assign DRW   = !isStore;
   assign IADDR = pc_q;
   assign DEBUG = {~RES, flush_q, DRD, DWR};

   always_comb begin
      DLEN  = DLEN_WORD;
      DATAO = '0;
      if (isLoad || isStore) begin
         case (funct3[1:0])
            2'b00:   DLEN = DLEN_BYTE;
            2'b01:   DLEN = DLEN_HALF;
            default: DLEN = DLEN_WORD;
         endcase
      end
      if (isStore) begin
         case (funct3[1:0])
            2'b00:   DATAO = {4{rs2Val[7:0]}};
            2'b01:   DATAO = {2{rs2Val[15:0]}};
            default: DATAO = rs2Val;
         endcase
      end
   end

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;
   logic [31:0] loadVal, wbData;
   logic        wbEn;

   assign loadHalf = DADDR[1] ? DATAI[31:16] : DATAI[15:0];

   always_comb begin
      loadByte = DATAI[7:0];
      case (DADDR[1:0])
         2'b01:   loadByte = DATAI[15:8];
         2'b10:   loadByte = DATAI[23:16];
         2'b11:   loadByte = DATAI[31:24];
         default: loadByte = DATAI[7:0];
      endcase
      loadVal = DATAI;
      case (funct3)
         F3_LB:   loadVal = {{24{loadByte[7]}}, loadByte};
         F3_LH:   loadVal = {{16{loadHalf[15]}}, loadHalf};
         F3_LBU:  loadVal = {24'd0, loadByte};
         F3_LHU:  loadVal = {16'd0, loadHalf};
         default: loadVal = DATAI;
      endcase
   end

   always_comb begin
      wbData = aluResult;
      wbEn   = isOp || isOpImm;
      if (isLui) begin
         wbData = immU;
         wbEn   = 1'b1;
      end else if (isAuipc) begin
         wbData = pcExec + immU;
         wbEn   = 1'b1;
      end else if (isJal || isJalr) begin
         wbData = pcExec + 32'd4;
         wbEn   = 1'b1;
      end else if (isLoad) begin
         wbData = loadVal;
         wbEn   = 1'b1;
      end
   end

   // Only x2 has a defined reset value; x0 is never written.
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         regs_q[2] <= RESET_SP;
      end else if (wbEn && !HLT && rd != 5'd0) begin
         regs_q[rd] <= wbData;
      end
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         pc_q     <= RESET_PC;
         ir_q     <= NOP_INSN;
         flush_q  <= 1'b1;
         halted_q <= 1'b0;
      end else begin
         ir_q     <= inst;
         halted_q <= HLT;
         if (!HLT) begin
            pc_q    <= pc_d;
            flush_q <= flush_d;
         end
      end
   end

endmodule

// File: tb/tb_darkriscv_core.sv
// Self-checking bench for darkriscv_core: small programs run from a
// synchronous instruction memory; every store on the bus is scoreboarded.
module tb_darkriscv_core;

   localparam logic [6:0] LUI = 7'b0110111, OPIMM = 7'b0010011, LOAD = 7'b0000011;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic        HLT = 1'b0;
   logic [31:0] idataQ = NOP;
   logic [31:0] IADDR, DADDR, DATAO;
   logic [31:0] dataIn = '0;
   logic [2:0]  DLEN;
   logic        DRW, DWR, DRD, DAS;
   logic [3:0]  DEBUG;

   int checks = 0;
   int errors = 0;

   logic [31:0] imem [0:255];
   logic [31:0] prog [$];

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  dlen;
   } storeExp_t;
   storeExp_t expQ [$];

   typedef struct {
      string       name;
      bit          isImm;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } aluVec_t;
   aluVec_t vecs [13];

   darkriscv_core #(.CPTR(0), .RESET_PC(32'h0), .RESET_SP(32'h2000)) dut (
      .CLK(CLK), .RES(RES), .HLT(HLT), .IDATA(idataQ), .IADDR(IADDR),
      .DADDR(DADDR), .DATAI(dataIn), .DATAO(DATAO), .DLEN(DLEN), .DRW(DRW),
      .DWR(DWR), .DRD(DRD), .DAS(DAS), .DEBUG(DEBUG)
   );

   always #5 CLK = ~CLK;

   // Synchronous instruction memory: word for the previous cycle's IADDR.
   always @(posedge CLK) idataQ <= imem[IADDR[9:2]];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Each completed store is compared against the oldest expectation.
   always @(negedge CLK) begin
      if (RES && DWR && !HLT) begin : monitor
         storeExp_t e;
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_store addr %h data %h expected none", DADDR, DATAO);
         end else begin
            e = expQ.pop_front();
            checkOutput({e.name, "_addr"}, DADDR, e.addr);
            checkOutput({e.name, "_data"}, DATAO, e.data);
            checkOutput({e.name, "_dlen"}, {29'd0, DLEN}, {29'd0, e.dlen});
         end
      end
   end

   function automatic logic [31:0] encR(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] encI(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] encS(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] encJ(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic loadConst(input logic [4:0] rd, input logic [31:0] c);
      logic [31:0] t;
      t = c + 32'h800;
      prog.push_back({t[31:12], rd, LUI});
      prog.push_back(encI(c[11:0], rd, 3'd0, rd, OPIMM));
   endtask

   task automatic expectStore(input string name, input logic [31:0] addr, input logic [31:0] data,
                              input logic [2:0] dlen);
      storeExp_t e;
      e.name = name;
      e.addr = addr;
      e.data = data;
      e.dlen = dlen;
      expQ.push_back(e);
   endtask

   // Loads prog into memory and leaves the core in reset at a falling edge.
   task automatic applyStimulus();
      RES = 1'b0;
      HLT = 1'b0;
      for (int i = 0; i < 256; i++) imem[i] = NOP;
      for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
      prog.delete();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drain(input string name, input int budget);
      for (int c = 0; c < budget && expQ.size() != 0; c++) @(posedge CLK);
      @(negedge CLK);
      checkOutput({name, "_drain_left"}, expQ.size(), 0);
      expQ.delete();
   endtask

   task automatic waitFor(input int which, input int budget);
      for (int c = 0; c < budget; c++) begin
         @(posedge CLK);
         #1;
         if (which == 0 && DWR) break;
         if (which == 1 && DRD) break;
      end
   endtask

   initial begin
      vecs[0]  = '{"add",   1'b0, 7'h00, 3'd0, 32'd5,          32'd7,          32'd12};
      vecs[1]  = '{"sub",   1'b0, 7'h20, 3'd0, 32'd5,          32'd7,          32'hFFFF_FFFE};
      vecs[2]  = '{"sll",   1'b0, 7'h00, 3'd1, 32'd3,          32'h21,         32'd6};
      vecs[3]  = '{"slt",   1'b0, 7'h00, 3'd2, 32'hFFFF_FFFF,  32'd1,          32'd1};
      vecs[4]  = '{"sltu",  1'b0, 7'h00, 3'd3, 32'hFFFF_FFFF,  32'd1,          32'd0};
      vecs[5]  = '{"xor",   1'b0, 7'h00, 3'd4, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  32'hFF00_FF00};
      vecs[6]  = '{"srl",   1'b0, 7'h00, 3'd5, 32'h8000_0000,  32'd4,          32'h0800_0000};
      vecs[7]  = '{"sra",   1'b0, 7'h20, 3'd5, 32'h8000_0000,  32'd4,          32'hF800_0000};
      vecs[8]  = '{"or",    1'b0, 7'h00, 3'd6, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678};
      vecs[9]  = '{"and",   1'b0, 7'h00, 3'd7, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'h0F0F_0000};
      vecs[10] = '{"srai",  1'b1, 7'h00, 3'd5, 32'h8000_1234,  32'h408,        32'hFF80_0012};
      vecs[11] = '{"addi",  1'b1, 7'h00, 3'd0, 32'd5,          32'hFF9,        32'hFFFF_FFFE};
      vecs[12] = '{"sltiu", 1'b1, 7'h00, 3'd3, 32'd5,          32'hFFF,        32'd1};

      // Reset state, first fetches, and x2 reset value stored to 0x100.
      prog.push_back(encS(12'h100, 5'd2, 5'd0, 3'd2));
      prog.push_back(encJ(21'd0, 5'd0));
      applyStimulus();
      checkOutput("rst_iaddr", IADDR, 32'h0);
      checkOutput("rst_strobes", {29'd0, DRD, DWR, DAS}, 32'd0);
      checkOutput("rst_drw", {31'd0, DRW}, 32'd1);
      checkOutput("rst_datao", DATAO, 32'h0);
      checkOutput("rst_dlen", {29'd0, DLEN}, 32'd4);
      checkOutput("rst_debug", {28'd0, DEBUG}, 32'hC);
      expectStore("sp_store", 32'h100, 32'h2000, 3'b100);
      RES = 1'b1;
      #1;
      checkOutput("iaddr_c0", IADDR, 32'h0);
      checkOutput("debug_c0", {28'd0, DEBUG}, 32'h4);
      @(posedge CLK); #1;
      checkOutput("iaddr_c1", IADDR, 32'h4);
      @(posedge CLK); #1;
      checkOutput("iaddr_c2", IADDR, 32'h8);
      drain("sp", 20);

      // ALU vector table, one store per vector.
      for (int i = 0; i < 13; i++) begin
         loadConst(5'd1, vecs[i].a);
         if (vecs[i].isImm) begin
            prog.push_back(encI(vecs[i].b[11:0], 5'd1, vecs[i].f3, 5'd3, OPIMM));
         end else begin
            loadConst(5'd2, vecs[i].b);
            prog.push_back(encR(vecs[i].f7, 5'd2, 5'd1, vecs[i].f3, 5'd3));
         end
         prog.push_back(encS(12'(256 + 4 * i), 5'd3, 5'd0, 3'd2));
         expectStore(vecs[i].name, 32'(256 + 4 * i), vecs[i].exp, 3'b100);
      end
      prog.push_back(encJ(21'd0, 5'd0));
      applyStimulus();
      RES = 1'b1;
      drain("alu", 300);

      // ADDI/SLTU chain and discarded write to x0.
      prog.push_back(encI(12'd5, 5'd0, 3'd0, 5'd1, OPIMM));
      prog.push_back(encI(12'hFF9, 5'd1, 3'd0, 5'd2, OPIMM));
      prog.push_back(encR(7'h00, 5'd2, 5'd1, 3'd3, 5'd3));
      prog.push_back(encI(12'd9, 5'd0, 3'd0, 5'd0, OPIMM));
      for (int r = 0; r < 4; r++) prog.push_back(encS(12'(256 + 4 * r), 5'(r == 3 ? 0 : r + 1), 5'd0, 3'd2));
      prog.push_back(encJ(21'd0, 5'd0));
      expectStore("x1", 32'h100, 32'd5, 3'b100);
      expectStore("x2", 32'h104, 32'hFFFF_FFFE, 3'b100);
      expectStore("x3", 32'h108, 32'd1, 3'b100);
      expectStore("x0", 32'h10C, 32'd0, 3'b100);
      applyStimulus();
      RES = 1'b1;
      drain("chain", 40);

      // Taken branch at 0x10 squashes the ADDI at 0x14.
      prog.push_back(encI(12'd7, 5'd0, 3'd0, 5'd5, OPIMM));
      prog.push_back(NOP);
      prog.push_back(NOP);
      prog.push_back(NOP);
      prog.push_back(encB(13'd8, 5'd0, 5'd0, 3'd0));
      prog.push_back(encI(12'd1, 5'd0, 3'd0, 5'd5, OPIMM));
      prog.push_back(encS(12'h100, 5'd5, 5'd0, 3'd2));
      prog.push_back(encJ(21'd0, 5'd0));
      expectStore("x5", 32'h100, 32'd7, 3'b100);
      applyStimulus();
      RES = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(posedge CLK); #1;
         if (IADDR == 32'h14) break;
      end
      checkOutput("br_exec_iaddr", IADDR, 32'h14);
      @(posedge CLK); #1;
      checkOutput("br_target_iaddr", IADDR, 32'h18);
      checkOutput("br_flush", {31'd0, DEBUG[2]}, 32'd1);
      drain("branch", 20);

      // Byte store replication and signed/unsigned byte loads from lane 3.
      dataIn = 32'hA512_3456;
      prog.push_back(encI(12'h0A5, 5'd0, 3'd0, 5'd1, OPIMM));
      prog.push_back(encS(12'h103, 5'd1, 5'd0, 3'd0));
      prog.push_back(encI(12'h103, 5'd0, 3'd0, 5'd2, LOAD));
      prog.push_back(encI(12'h103, 5'd0, 3'd4, 5'd3, LOAD));
      prog.push_back(encS(12'h200, 5'd2, 5'd0, 3'd2));
      prog.push_back(encS(12'h204, 5'd3, 5'd0, 3'd2));
      prog.push_back(encJ(21'd0, 5'd0));
      expectStore("sb", 32'h103, 32'hA5A5_A5A5, 3'b001);
      expectStore("lb", 32'h200, 32'hFFFF_FFA5, 3'b100);
      expectStore("lbu", 32'h204, 32'h0000_00A5, 3'b100);
      applyStimulus();
      RES = 1'b1;
      waitFor(0, 20);
      checkOutput("sb_datao", DATAO, 32'hA5A5_A5A5);
      checkOutput("sb_dlen", {29'd0, DLEN}, 32'd1);
      checkOutput("sb_dwr_das_drw", {29'd0, DWR, DAS, DRW}, 32'b110);
      drain("bytes", 30);
      dataIn = '0;

      // Three stalled cycles during LW; only the post-stall DATAI is written.
      prog.push_back(encI(12'h080, 5'd0, 3'd2, 5'd4, LOAD));
      prog.push_back(encS(12'h100, 5'd4, 5'd0, 3'd2));
      prog.push_back(encJ(21'd0, 5'd0));
      expectStore("lw_hlt", 32'h100, 32'hCAFE_F00D, 3'b100);
      applyStimulus();
      RES = 1'b1;
      waitFor(1, 20);
      checkOutput("lw_drd", {31'd0, DRD}, 32'd1);
      HLT = 1'b1;
      for (int k = 0; k < 3; k++) begin
         dataIn = 32'h1111_1111 * 32'(k + 1);
         @(posedge CLK); #1;
         checkOutput($sformatf("hlt_iaddr_%0d", k), IADDR, 32'h4);
         checkOutput($sformatf("hlt_strobe_%0d", k), {29'd0, DRD, DAS, DWR}, 32'b110);
         checkOutput($sformatf("hlt_daddr_%0d", k), DADDR, 32'h80);
      end
      dataIn = 32'hCAFE_F00D;
      HLT = 1'b0;
      drain("halt", 20);
      dataIn = '0;

      // Reset asserted mid-store, then restart from RESET_PC.
      prog.push_back(encS(12'h100, 5'd2, 5'd0, 3'd2));
      prog.push_back(encJ(21'd0, 5'd0));
      applyStimulus();
      RES = 1'b1;
      waitFor(0, 20);
      checkOutput("pre_rst_dwr", {31'd0, DWR}, 32'd1);
      RES = 1'b0;
      #1;
      checkOutput("mid_rst_strobes", {30'd0, DWR, DAS}, 32'd0);
      checkOutput("mid_rst_iaddr", IADDR, 32'h0);
      expectStore("restart", 32'h100, 32'h2000, 3'b100);
      @(negedge CLK);
      RES = 1'b1;
      #1;
      checkOutput("restart_iaddr", IADDR, 32'h0);
      drain("restart", 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
